// File: rtl/eth_pkg.sv
// eth_pkg: header layout, protocol constants and expected-header builder for the eth rx pipe.
// Header byte k sits at bits [8k+7:8k] of the reference vectors, so a beat's expected bytes
// are a plain part-select at beat_index*DATA_W.
package eth_pkg;

    localparam int HEAD_MAX     = 54;  // VLAN-tagged header incl. preamble
    localparam int MAC_DST_OFF  = 8;
    localparam int VLAN_OFF     = 20;
    localparam int IP_PROTO_OFF = 9;
    localparam int IP_DST_OFF   = 16;
    localparam int UDP_DST_OFF  = 2;
    localparam int UDP_LEN_OFF  = 4;

    localparam logic [7:0]  PREAMBLE       = 8'h55;
    localparam logic [7:0]  SFD            = 8'hD5;
    localparam logic [15:0] TPID           = 16'h8100;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_DATA, S_DROP} rx_state_e;

    // Expected header bytes plus a per-bit mask; mask bits are 1 only on checked bytes.
    typedef struct packed {
        logic [HEAD_MAX*8-1:0] bytes;
        logic [HEAD_MAX*8-1:0] mask;
    } head_ref_t;

    function automatic int ethertype_off(input int vlan);
        return 20 + 4 * vlan;
    endfunction

    function automatic int ip_off(input int vlan);
        return ethertype_off(vlan) + 2;
    endfunction

    function automatic int udp_off(input int vlan);
        return ip_off(vlan) + 20;
    endfunction

    function automatic int head_n(input int vlan);
        return udp_off(vlan) + 8;
    endfunction

    function automatic head_ref_t put_byte(input head_ref_t r, input int k, input logic [7:0] b);
        head_ref_t o;
        o = r;
        o.bytes[8*k +: 8] = b;
        o.mask[8*k +: 8]  = 8'hFF;
        return o;
    endfunction

    function automatic head_ref_t head_ref(input int vlan, input logic [47:0] mac,
                                           input logic [31:0] ip, input logic [15:0] port);
        head_ref_t r;
        int e;
        int i;
        int u;
        r = '0;
        e = ethertype_off(vlan);
        i = ip_off(vlan);
        u = udp_off(vlan);
        for (int k = 0; k < 7; k++) r = put_byte(r, k, PREAMBLE);
        r = put_byte(r, 7, SFD);
        for (int k = 0; k < 6; k++) r = put_byte(r, MAC_DST_OFF + k, mac[8*(5-k) +: 8]);
        if (vlan != 0) begin
            r = put_byte(r, VLAN_OFF, TPID[15:8]);
            r = put_byte(r, VLAN_OFF + 1, TPID[7:0]);
        end
        r = put_byte(r, e, ETHERTYPE_IPV4[15:8]);
        r = put_byte(r, e + 1, ETHERTYPE_IPV4[7:0]);
        r = put_byte(r, i, IP_VER_IHL);
        r = put_byte(r, i + IP_PROTO_OFF, IP_PROTO_UDP);
        for (int k = 0; k < 4; k++) r = put_byte(r, i + IP_DST_OFF + k, ip[8*(3-k) +: 8]);
        r = put_byte(r, u + UDP_DST_OFF, port[15:8]);
        r = put_byte(r, u + UDP_DST_OFF + 1, port[7:0]);
        return r;
    endfunction

endpackage

// File: rtl/eth_rx_head_chk.sv
// eth_rx_head_chk: compares one header beat against the configured header and captures udp_len.
// Ports: clk/reset; beat_en_i (header beat consumed); idx_i (beat index within header);
//        data_i (beat data); match_o (all checked bytes of this beat match);
//        udp_len_o (udp_len including any bytes carried by the current beat).
module eth_rx_head_chk
    import eth_pkg::*;
#(
    parameter int          DATA_W       = 16,
    parameter int          KEEP_W       = DATA_W / 8,
    parameter int          IDX_W        = 5,
    parameter int          VLAN_TAG     = 1,
    parameter logic [47:0] MAC_DST_ADDR = 48'h0000_00FC_D4F2,
    parameter logic [31:0] IP_DST_ADDR  = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [15:0] DST_PORT     = 16'd18170
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beat_en_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              match_o,
    output logic [15:0]       udp_len_o
);

    localparam head_ref_t REF         = head_ref(VLAN_TAG, MAC_DST_ADDR, IP_DST_ADDR, DST_PORT);
    localparam int        UDP_LEN_POS = udp_off(VLAN_TAG) + UDP_LEN_OFF;

    logic [DATA_W-1:0] exp_b;
    logic [DATA_W-1:0] mask_b;
    logic [15:0]       udp_len_d;
    logic [15:0]       udp_len_q;

    always_comb begin
        exp_b     = REF.bytes[int'(idx_i)*DATA_W +: DATA_W];
        mask_b    = REF.mask[int'(idx_i)*DATA_W +: DATA_W];
        match_o   = ((data_i ^ exp_b) & mask_b) == '0;
        udp_len_d = udp_len_q;
        for (int l = 0; l < KEEP_W; l++) begin
            if (int'(idx_i) * KEEP_W + l == UDP_LEN_POS)     udp_len_d[15:8] = data_i[8*l +: 8];
            if (int'(idx_i) * KEEP_W + l == UDP_LEN_POS + 1) udp_len_d[7:0]  = data_i[8*l +: 8];
        end
    end

    assign udp_len_o = udp_len_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udp_len_q <= '0;
        end else if (beat_en_i) begin
            udp_len_q <= udp_len_d;
        end
    end

endmodule

// File: rtl/eth_rx.sv
// eth_rx: MAC rx beats -> header check (MAC/VLAN/IPv4/UDP) -> UDP payload stream to the app.
// Ports: clk, reset (async active-high, released synchronously inside);
//        mac_valid_i/start_i/data_i/term_i/term_keep_i: MAC rx lane, preamble onward;
//        app_early_v_o + app_pkt_len_o: header accepted, payload length;
//        app_valid_o/data_o/len_o/last_o: payload beats; app_cancel_o: payload aborted.
module eth_rx
    import eth_pkg::*;
#(
    parameter int          DATA_W       = 16,
    parameter int          KEEP_W       = DATA_W / 8,
    parameter int          LEN_W        = $clog2(KEEP_W + 1),
    parameter int          PKT_LEN_W    = 16,
    parameter int          VLAN_TAG     = 1,
    parameter logic [47:0] MAC_DST_ADDR = 48'h0000_00FC_D4F2,
    parameter logic [31:0] IP_DST_ADDR  = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [15:0] DST_PORT     = 16'd18170
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mac_valid_i,
    input  logic                 mac_start_i,
    input  logic [DATA_W-1:0]    mac_data_i,
    input  logic                 mac_term_i,
    input  logic [KEEP_W-1:0]    mac_term_keep_i,
    output logic                 app_early_v_o,
    output logic [PKT_LEN_W-1:0] app_pkt_len_o,
    output logic                 app_valid_o,
    output logic [DATA_W-1:0]    app_data_o,
    output logic [LEN_W-1:0]     app_len_o,
    output logic                 app_last_o,
    output logic                 app_cancel_o
);

    localparam int               HEAD_N     = head_n(VLAN_TAG);
    localparam int               HEAD_BEATS = HEAD_N / KEEP_W;
    localparam int               IDX_W      = $clog2(HEAD_BEATS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(HEAD_BEATS - 1);

    if (HEAD_N % KEEP_W != 0) begin : g_bad_width
        $error("eth_rx: header length %0d is not a multiple of KEEP_W %0d", HEAD_N, KEEP_W);
    end

    // Reset asserts immediately, deasserts two clocks after the external reset falls.
    logic rst_meta_q;
    logic rst_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_meta_q <= 1'b1;
            rst_q      <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_q      <= rst_meta_q;
        end
    end

    rx_state_e            state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [PKT_LEN_W-1:0] rem_q, rem_d;
    logic                 early_q, early_d;
    logic [PKT_LEN_W-1:0] pkt_len_q, pkt_len_d;
    logic                 valid_q, valid_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 last_q, last_d;
    logic                 cancel_q, cancel_d;

    logic                 hit;
    logic [15:0]          udp_len;
    logic                 beat_en;
    logic [IDX_W-1:0]     chk_idx;
    logic [PKT_LEN_W-1:0] keep_cnt;
    logic [PKT_LEN_W-1:0] beat_bytes;
    logic [PKT_LEN_W-1:0] out_len;
    logic [PKT_LEN_W-1:0] payload;
    logic                 done;
    logic                 last_head;
    logic                 ok;

    // A start beat is always header beat 0; outside HEAD the index is parked at 0.
    assign beat_en = mac_valid_i && (mac_start_i || state_q == S_HEAD);
    assign chk_idx = (mac_start_i || state_q != S_HEAD) ? '0 : idx_q;

    eth_rx_head_chk #(
        .DATA_W       (DATA_W),
        .KEEP_W       (KEEP_W),
        .IDX_W        (IDX_W),
        .VLAN_TAG     (VLAN_TAG),
        .MAC_DST_ADDR (MAC_DST_ADDR),
        .IP_DST_ADDR  (IP_DST_ADDR),
        .DST_PORT     (DST_PORT)
    ) u_head_chk (
        .clk       (clk),
        .reset     (rst_q),
        .beat_en_i (beat_en),
        .idx_i     (chk_idx),
        .data_i    (mac_data_i),
        .match_o   (hit),
        .udp_len_o (udp_len)
    );

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < KEEP_W; i++) keep_cnt = keep_cnt + PKT_LEN_W'(mac_term_keep_i[i]);
        beat_bytes = mac_term_i ? keep_cnt : PKT_LEN_W'(KEEP_W);
        // A beat finishes the payload once it carries at least the remaining bytes.
        done      = beat_bytes >= rem_q;
        out_len   = done ? rem_q : beat_bytes;
        payload   = PKT_LEN_W'(udp_len) - PKT_LEN_W'(8);
        last_head = idx_q == LAST_IDX;
        ok        = hit && (!last_head || udp_len >= 16'd8);
        state_d   = state_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        early_d   = 1'b0;
        pkt_len_d = pkt_len_q;
        valid_d   = 1'b0;
        data_d    = '0;
        len_d     = '0;
        last_d    = 1'b0;
        cancel_d  = 1'b0;
        if (mac_valid_i && mac_start_i) begin
            cancel_d = state_q == S_DATA;
            idx_d    = IDX_W'(1);
            state_d  = mac_term_i ? S_IDLE : hit ? S_HEAD : S_DROP;
        end else if (mac_valid_i) begin
            case (state_q)
                S_HEAD: begin
                    idx_d     = idx_q + IDX_W'(1);
                    // A term on the final header beat still reports an empty payload.
                    early_d   = last_head && ok && (!mac_term_i || payload == '0);
                    pkt_len_d = early_d ? payload : pkt_len_q;
                    rem_d     = payload;
                    state_d   = mac_term_i ? S_IDLE : !ok ? S_DROP : !last_head ? S_HEAD :
                                payload == '0 ? S_DROP : S_DATA;
                end
                S_DATA: begin
                    valid_d  = out_len != '0;
                    data_d   = mac_data_i;
                    len_d    = LEN_W'(out_len);
                    last_d   = done;
                    cancel_d = mac_term_i && !done;
                    rem_d    = rem_q - out_len;
                    state_d  = mac_term_i ? S_IDLE : done ? S_DROP : S_DATA;
                end
                S_DROP:  state_d = mac_term_i ? S_IDLE : S_DROP;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_q) begin
        if (rst_q) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            rem_q     <= '0;
            early_q   <= 1'b0;
            pkt_len_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            len_q     <= '0;
            last_q    <= 1'b0;
            cancel_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            early_q   <= early_d;
            pkt_len_q <= pkt_len_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            len_q     <= len_d;
            last_q    <= last_d;
            cancel_q  <= cancel_d;
        end
    end

    assign app_early_v_o = early_q;
    assign app_pkt_len_o = pkt_len_q;
    assign app_valid_o   = valid_q;
    assign app_data_o    = data_q;
    assign app_len_o     = len_q;
    assign app_last_o    = last_q;
    assign app_cancel_o  = cancel_q;

endmodule
